booth_share_ctrl: RTL and testbench
===================================

Name: booth_share_ctrl

Overview:
- Controller that shares one radix-2 Booth multiplier datapath (A/Q/M registers with add/sub and arithmetic shift) between two requesters.
- Round-robin arbitration between the requesters.
- For the granted requester: selects its operands, loads M/Q, runs N Booth iterations and returns a one-cycle done pulse.
- Replaces a single-user fixed 3-iteration sequencer with a parameterised, counter-driven, handshaked controller.

Parameters:
- N, default 3: operand width in bits, equal to the number of Booth iterations (N >= 2).
- CW, default 2: iteration counter width; must satisfy 2**CW > N.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  2  request lines; req[i] is held high by requester i until done[i] is seen.
- q  in  2  datapath {Q[0], Q[-1]} Booth pair.
- gnt  out  2  registered one-hot grant; 00 when idle.
- sel  out  1  datapath operand mux select (0 = requester 0, 1 = requester 1); equals the index of the granted requester.
- cargaM  out  1  load M register from the selected operand.
- cargaQ  out  1  load Q register from the selected operand and clear Q[-1] and A.
- cargaA  out  1  write adder/subtractor result into A.
- resta  out  1  adder operation: 1 = A-M, 0 = A+M.
- desp  out  1  arithmetic right shift of {A,Q,Q[-1]}.
- busy  out  1  high in every state except IDLE.
- done  out  2  one-cycle pulse on the granted requester's bit when the product is valid in {A,Q}.

Behaviour:
- Reset (synchronous, any state, including mid-operation):
  - state = IDLE, gnt = 00, done = 00, counter = 0.
  - Round-robin pointer set so requester 0 wins the next tie.
  - All control outputs are 0 while in IDLE. Datapath contents are don't-care.
- State machine: IDLE, LOAD, EVAL, ADD, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req bit high: grant it.
  - Both high: grant the requester not served last.
  - On a grant, the next state is LOAD, gnt is registered, and sel follows gnt.
- LOAD (1 cycle): cargaM = cargaQ = 1, counter cleared to 0. Next state: EVAL.
- EVAL:
  - q = 00 or 11: desp = 1 and counter increments. If the counter was N-1, next state is DONE; otherwise stay in EVAL.
  - q = 01 or 10: cargaA = 1, with resta = 1 for 10 and 0 for 01. Next state is ADD.
- ADD: desp = 1 and counter increments. If the counter was N-1, next state is DONE; otherwise next state is EVAL.
- DONE (1 cycle):
  - done[sel] = 1, busy = 1.
  - Round-robin pointer updated to "last served = sel".
  - Next state is IDLE; gnt clears on entry to IDLE.
- Decode rules:
  - resta is a combinational decode of q in all states; it only has effect when cargaA = 1.
  - cargaA and desp are never high in the same cycle.
  - Control outputs are combinational decodes of state, plus q in EVAL (Mealy).
- Latency: grant-to-done = 1 (LOAD) + N (shifts) + k (add/sub cycles, 0 <= k <= N) + 1 (DONE) cycles after the grant edge.
  - Minimum N+2 cycles, maximum 2N+2.
- Handshake:
  - A requester must drop req in the cycle after done is high. A req still high in the IDLE cycle after DONE is treated as a new request.
  - req deassertion while granted is ignored; the operation completes and done still pulses.
  - Operands on the non-granted side may change freely. The granted side's operands must be stable through LOAD only.
- Simultaneous events:
  - A new req arriving while busy waits; it is not lost as long as it is held.
  - If both requesters are waiting at IDLE, strict alternation applies.
- Counter never exceeds N-1 before the exit transition. The default branch of the state decode returns to IDLE.

Test Plan:
- Single request (N=3, bench datapath model): req=01, op0 M=3, Q=2 (010).
  - Required trace after grant: LOAD, EVAL(desp), EVAL(cargaA, resta=1), ADD(desp), EVAL(cargaA, resta=0), ADD(desp), DONE.
  - done=01 exactly 7 cycles after gnt=01; {A,Q} = 6.
- Tie after reset: req=11 held from reset release.
  - gnt=01 first, done=01.
  - Requester 0 drops req; then gnt=10, done=10 next.
  - No overlap; busy high throughout except the IDLE cycle between operations.
- Fairness: requester 0 re-raises req immediately after each done while req[1] stays high.
  - Grants alternate 01, 10, 01, 10 over 4 operations.
- Signed/extreme operands (N=3): M=-4 (100), Q=-4 (100).
  - q pattern 00, 00, 10 gives 2 desp-only EVALs plus 1 subtract.
  - Product {A,Q} = 16; done 6 cycles after grant.
- Reset mid-operation: assert reset for 1 cycle while in ADD.
  - Next cycle: gnt=00, busy=0, done=00, all control signals 0.
  - With req=11 held, requester 0 is granted first.
- Hold rule: requester keeps req=1 for one cycle after done.
  - The controller re-grants it and runs a second full operation with a second done pulse.

Source files
------------

// File: rtl/booth_share_ctrl.sv
// Controller that shares a single radix-2 Booth multiplier datapath between
// two requesters. It arbitrates round-robin, loads the winner's operands,
// sequences N Booth iterations and pulses done on the winner's bit.
module booth_share_ctrl #(
  parameter int unsigned N  = 3,  // operand width == number of Booth iterations
  parameter int unsigned CW = 2   // iteration counter width, 2**CW > N
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] q,       // {Q[0], Q[-1]}
  output logic [1:0] gnt,
  output logic       sel,
  output logic       cargaM,
  output logic       cargaQ,
  output logic       cargaA,
  output logic       resta,
  output logic       desp,
  output logic       busy,
  output logic [1:0] done
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StEval,
    StAdd,
    StDone
  } state_e;

  localparam logic [CW-1:0] LastCnt = CW'(N - 1);

  state_e        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Index of the requester served most recently; the other one wins a tie.
  logic          last_q, last_d;

  // State, grant, iteration counter and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      gnt_q   <= 2'b00;
      cnt_q   <= '0;
      last_q  <= 1'b1;  // requester 0 wins the first tie
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign gnt  = gnt_q;
  assign sel  = gnt_q[1];
  assign busy = (state_q != StIdle);

  // Next-state logic and Mealy control decode for the datapath.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    cargaM  = 1'b0;
    cargaQ  = 1'b0;
    cargaA  = 1'b0;
    desp    = 1'b0;
    done    = 2'b00;
    // Add/sub direction is a plain decode of the Booth pair; it only matters
    // when cargaA is set. Kept quiet in IDLE so the idle controller is silent.
    resta   = (q == 2'b10) && (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        unique case (req)
          2'b01:   gnt_d = 2'b01;
          2'b10:   gnt_d = 2'b10;
          2'b11:   gnt_d = last_q ? 2'b01 : 2'b10;
          default: gnt_d = 2'b00;
        endcase
        if (req != 2'b00) state_d = StLoad;
      end
      StLoad: begin
        cargaM  = 1'b1;
        cargaQ  = 1'b1;
        cnt_d   = '0;
        state_d = StEval;
      end
      StEval: begin
        if (q[1] ^ q[0]) begin
          cargaA  = 1'b1;
          state_d = StAdd;
        end else begin
          desp  = 1'b1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LastCnt) state_d = StDone;
        end
      end
      StAdd: begin
        desp    = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == LastCnt) ? StDone : StEval;
      end
      StDone: begin
        done    = gnt_q;
        last_d  = gnt_q[1];
        gnt_d   = 2'b00;
        state_d = StIdle;
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_booth_share_ctrl.sv
// Bench for booth_share_ctrl: a small A/Q/M datapath model closes the loop on
// q, and a reference model predicts grant order, latency and product.
module tb_booth_share_ctrl;
  localparam int unsigned N  = 3;
  localparam int unsigned CW = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] q;
  logic [1:0] gnt, done;
  logic       sel, cargaM, cargaQ, cargaA, resta, desp, busy;

  int total = 0;
  int bad   = 0;
  int last_srv = 1;  // reference round-robin state: index served last

  logic [N-1:0] opM [2];
  logic [N-1:0] opQ [2];

  // Datapath model; A has one guard bit so M = -2**(N-1) is representable.
  logic signed [N:0] dA = '0;
  logic [N-1:0]      dQ = '0;
  logic [N-1:0]      dM = '0;
  logic              dQm1 = 1'b0;

  logic [5:0] trace [32];

  always #5 clk = ~clk;

  booth_share_ctrl #(.N(N), .CW(CW)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .q      (q),
    .gnt    (gnt),
    .sel    (sel),
    .cargaM (cargaM),
    .cargaQ (cargaQ),
    .cargaA (cargaA),
    .resta  (resta),
    .desp   (desp),
    .busy   (busy),
    .done   (done)
  );

  assign q = {dQ[0], dQm1};

  always @(posedge clk) begin
    if (cargaQ) begin
      dQ   <= opQ[sel];
      dQm1 <= 1'b0;
      dA   <= '0;
    end
    if (cargaM) dM <= opM[sel];
    if (cargaA) dA <= resta ? dA - $signed({dM[N-1], dM}) : dA + $signed({dM[N-1], dM});
    if (desp) {dA, dQ, dQm1} <= {dA[N], dA, dQ};
  end

  // Number of add/sub steps = number of bit transitions in {Q, 0}.
  function automatic int booth_adds(input logic [N-1:0] v);
    int   k = 0;
    logic prev = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (v[i] != prev) k++;
      prev = v[i];
    end
    return k;
  endfunction

  function automatic int ref_prod(input logic [N-1:0] m, input logic [N-1:0] v);
    return int'($signed(m)) * int'($signed(v));
  endfunction

  function automatic int dp_prod();
    logic signed [2*N:0] p;
    p = $signed({dA, dQ});
    return int'(p);
  endfunction

  function automatic int ref_grant(input logic [1:0] r);
    if (r == 2'b11) return (last_srv == 1) ? 0 : 1;
    return r[1] ? 1 : 0;
  endfunction

  // Steps cycles until done pulses; records observations, never judges them.
  task automatic wait_done(output int lat, output logic [1:0] g, output logic [1:0] d,
                           output int excl, output int ncyc);
    int gcyc;
    lat = -1; g = 2'b00; d = 2'b00; excl = 0; gcyc = -1; ncyc = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (cargaA && desp) excl++;
      if (gnt != 2'b00 && !busy) excl++;
      if (gcyc < 0 && gnt != 2'b00) begin
        gcyc = c;
        g = gnt;
      end
      if (gcyc >= 0 && ncyc < 32) begin
        trace[ncyc] = {cargaM, cargaQ, cargaA, resta & cargaA, desp, |done};
        ncyc++;
      end
      if (done != 2'b00) begin
        d = done;
        lat = c - gcyc + 1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({gnt, done, busy} !== 5'b0) begin
      bad++;
      $display("FAIL reset_state: gnt=%b done=%b busy=%b want 00 00 0", gnt, done, busy);
    end
    total++;
    if ({cargaM, cargaQ, cargaA, desp} !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctrl: ctrl=%b want 0000", {cargaM, cargaQ, cargaA, desp});
    end
    reset = 1'b0;
    last_srv = 1;
  endtask

  task automatic test_single();
    int lat, excl, n;
    logic [1:0] g, d;
    logic [5:0] exp_tr [7];
    exp_tr = '{6'b110000, 6'b000010, 6'b001100, 6'b000010, 6'b001000, 6'b000010, 6'b000001};
    opM[0] = 3'd3; opQ[0] = 3'd2; opM[1] = 3'd5; opQ[1] = 3'd7;
    req = 2'b01;
    wait_done(lat, g, d, excl, n);
    req = 2'b00;
    total++;
    if (g !== 2'b01 || d !== 2'b01) begin
      bad++;
      $display("FAIL single_gnt_done: gnt=%b done=%b want 01 01", g, d);
    end
    total++;
    if (lat != 7) begin
      bad++;
      $display("FAIL single_latency: got %0d want 7", lat);
    end
    total++;
    if (dp_prod() != 6) begin
      bad++;
      $display("FAIL single_product: got %0d want 6", dp_prod());
    end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (i >= n || trace[i] !== exp_tr[i]) begin
        bad++;
        $display("FAIL single_trace[%0d]: got %b want %b", i, trace[i], exp_tr[i]);
      end
    end
    last_srv = 0;
  endtask

  task automatic test_tie();
    int lat, excl, n;
    logic [1:0] g, d;
    @(negedge clk);
    reset = 1'b1;
    req = 2'b11;
    opM[0] = 3'd1; opQ[0] = 3'd3; opM[1] = 3'd2; opQ[1] = 3'd7;
    @(negedge clk);
    reset = 1'b0;
    last_srv = 1;
    wait_done(lat, g, d, excl, n);
    req = 2'b10;
    total++;
    if (g !== 2'b01 || d !== 2'b01 || lat != int'(N) + 2 + booth_adds(opQ[0])) begin
      bad++;
      $display("FAIL tie_first: gnt=%b done=%b lat=%0d want 01 01 %0d", g, d, lat,
               int'(N) + 2 + booth_adds(opQ[0]));
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || gnt !== 2'b00) begin
      bad++;
      $display("FAIL tie_idle_gap: busy=%b gnt=%b want 0 00", busy, gnt);
    end
    wait_done(lat, g, d, excl, n);
    req = 2'b00;
    total++;
    if (g !== 2'b10 || d !== 2'b10 || excl != 0) begin
      bad++;
      $display("FAIL tie_second: gnt=%b done=%b excl=%0d want 10 10 0", g, d, excl);
    end
    total++;
    if (dp_prod() != ref_prod(opM[1], opQ[1])) begin
      bad++;
      $display("FAIL tie_product: got %0d want %0d", dp_prod(), ref_prod(opM[1], opQ[1]));
    end
    last_srv = 1;
  endtask

  task automatic test_fairness();
    int lat, excl, n, eg;
    logic [1:0] g, d;
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      eg = ref_grant(req);
      wait_done(lat, g, d, excl, n);
      total++;
      if (g !== (2'b01 << eg) || d !== (2'b01 << eg)) begin
        bad++;
        $display("FAIL fairness_op%0d: gnt=%b done=%b want %b", i, g, d, 2'b01 << eg);
      end
      last_srv = eg;
    end
    req = 2'b00;
  endtask

  task automatic test_hold();
    int lat, excl, n;
    logic [1:0] g, d;
    opM[0] = 3'd2; opQ[0] = 3'd3;
    req = 2'b01;
    wait_done(lat, g, d, excl, n);
    // req stays high through the IDLE cycle: a fresh request
    wait_done(lat, g, d, excl, n);
    req = 2'b00;
    total++;
    if (g !== 2'b01 || d !== 2'b01 || lat != int'(N) + 2 + booth_adds(opQ[0])) begin
      bad++;
      $display("FAIL hold_regrant: gnt=%b done=%b lat=%0d want 01 01 %0d", g, d, lat,
               int'(N) + 2 + booth_adds(opQ[0]));
    end
    last_srv = 0;
  endtask

  task automatic test_extreme();
    int lat, excl, n;
    logic [1:0] g, d;
    opM[0] = 3'b100; opQ[0] = 3'b100;
    req = 2'b01;
    wait_done(lat, g, d, excl, n);
    req = 2'b00;
    total++;
    if (lat != 6 || d !== 2'b01) begin
      bad++;
      $display("FAIL extreme_latency: lat=%0d done=%b want 6 01", lat, d);
    end
    total++;
    if (dp_prod() != 16) begin
      bad++;
      $display("FAIL extreme_product: got %0d want 16", dp_prod());
    end
    last_srv = 0;
  endtask

  task automatic test_reset_mid();
    int lat, excl, n;
    int guard;
    logic [1:0] g, d;
    opM[0] = 3'd3; opQ[0] = 3'd2;
    req = 2'b01;
    guard = 0;
    @(negedge clk);
    while (!cargaA && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);  // now in ADD
    total++;
    if (desp !== 1'b1 || guard >= 50) begin
      bad++;
      $display("FAIL midreset_reach_add: desp=%b guard=%0d want 1 <50", desp, guard);
    end
    reset = 1'b1;
    req = 2'b11;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({gnt, done, busy} !== 5'b0 || {cargaM, cargaQ, cargaA, desp} !== 4'b0) begin
      bad++;
      $display("FAIL midreset_state: gnt=%b done=%b busy=%b ctrl=%b want 00 00 0 0000",
               gnt, done, busy, {cargaM, cargaQ, cargaA, desp});
    end
    last_srv = 1;
    wait_done(lat, g, d, excl, n);
    req = 2'b00;
    total++;
    if (g !== 2'b01 || d !== 2'b01) begin
      bad++;
      $display("FAIL midreset_first_grant: gnt=%b done=%b want 01 01", g, d);
    end
    last_srv = 0;
  endtask

  task automatic test_random();
    int lat, excl, n, eg, elat, ep;
    logic [1:0] g, d, p;
    for (int i = 0; i < 20; i++) begin
      for (int s = 0; s < 2; s++) begin
        opM[s] = N'($urandom);
        opQ[s] = N'($urandom);
      end
      p = 2'($urandom_range(1, 3));
      req = p;
      eg = ref_grant(p);
      elat = int'(N) + 2 + booth_adds(opQ[eg]);
      ep = ref_prod(opM[eg], opQ[eg]);
      wait_done(lat, g, d, excl, n);
      total++;
      if (g !== (2'b01 << eg) || d !== (2'b01 << eg) || lat != elat || excl != 0) begin
        bad++;
        $display("FAIL random_op%0d: gnt=%b done=%b lat=%0d excl=%0d want %b %b %0d 0",
                 i, g, d, lat, excl, 2'b01 << eg, 2'b01 << eg, elat);
      end
      total++;
      if (dp_prod() != ep) begin
        bad++;
        $display("FAIL random_prod%0d: got %0d want %0d", i, dp_prod(), ep);
      end
      last_srv = eg;
    end
    req = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    opM[0] = '0; opM[1] = '0; opQ[0] = '0; opQ[1] = '0;
    test_reset();
    test_single();
    @(negedge clk);
    test_tie();
    @(negedge clk);
    test_fairness();
    @(negedge clk);
    test_hold();
    @(negedge clk);
    test_extreme();
    @(negedge clk);
    test_reset_mid();
    @(negedge clk);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
